// File: rtl/cargador_color_pkg.sv
// cargador_color_pkg: colour width, debounce default and capture FSM encoding shared with the downstream timer
package cargador_color_pkg;
    localparam int COLOR_W = 5;
    localparam int DEBOUNCE_CYCLES_DEF = 16;
    typedef enum logic [1:0] {CAP_R, CAP_G, CAP_B, FIRE} state_t;
endpackage

// File: rtl/cargador_color_antirrebote.sv
// antirrebote: synchronizes and debounces a raw pushbutton, emitting a one-clock pulse per press
module antirrebote
    import cargador_color_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
    logic s1, s2, lvl, lvl_q;
    logic [CW-1:0] cnt;
    // two-flop synchronizer for the asynchronous button
    always_ff @(posedge clk or posedge reset) begin
        if (reset) {s2, s1} <= 2'b00;
        else {s2, s1} <= {s1, btn};
    end
    // accept a new level only after it has persisted for DEBOUNCE_CYCLES clocks
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
            lvl <= 1'b0;
        end else if (s2 == lvl) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
            lvl <= s2;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
    // registered rising-edge detect; releases produce nothing
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lvl_q <= 1'b0;
            press <= 1'b0;
        end else begin
            lvl_q <= lvl;
            press <= lvl & ~lvl_q;
        end
    end
endmodule

// File: rtl/cargador_color.sv
// cargador_color: captures switch values into R, G, B on successive presses, then pulses enter
module cargador_color
    import cargador_color_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int COLOR_W = cargador_color_pkg::COLOR_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               btn,
    input  logic [COLOR_W-1:0] sw,
    output logic [COLOR_W-1:0] R,
    output logic [COLOR_W-1:0] G,
    output logic [COLOR_W-1:0] B,
    output logic               enter,
    output logic [2:0]         sel
);
    state_t state, nxt;
    logic press;
    antirrebote #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_antirrebote (
        .clk(clk),
        .reset(reset),
        .btn(btn),
        .press(press)
    );
    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= CAP_R;
        else state <= nxt;
    end
    // advance one target per press; FIRE always returns to CAP_R after one clock
    always_comb begin
        nxt = state == FIRE ? CAP_R :
              !press        ? state :
              state == CAP_R ? CAP_G :
              state == CAP_G ? CAP_B : FIRE;
    end
    // one-hot target select and start pulse decoded from the state register
    always_comb begin
        sel = state == CAP_R ? 3'b001 :
              state == CAP_G ? 3'b010 :
              state == CAP_B ? 3'b100 : 3'b000;
        enter = state == FIRE;
    end
    // each colour register loads only on a press in its own capture state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            R <= '0;
            G <= '0;
            B <= '0;
        end else if (press) begin
            if (state == CAP_R) R <= sw;
            if (state == CAP_G) G <= sw;
            if (state == CAP_B) B <= sw;
        end
    end
endmodule

// File: tb/tb_cargador_color.sv
// tb_cargador_color: directed stimulus checked every cycle against a behavioural model of the loader
module tb_cargador_color;
    localparam int D = 4;
    localparam int W = 5;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic btn = 1'b0;
    logic [W-1:0] sw = '0;
    logic [W-1:0] R, G, B;
    logic enter;
    logic [2:0] sel;
    int n_chk = 0;
    int n_fail = 0;
    int n_enter = 0;
    int e0;
    int lat;

    cargador_color #(.DEBOUNCE_CYCLES(D), .COLOR_W(W)) dut (
        .clk(clk),
        .reset(reset),
        .btn(btn),
        .sw(sw),
        .R(R),
        .G(G),
        .B(B),
        .enter(enter),
        .sel(sel)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: history of btn samples; level flips once the synchronized samples
    // (two clocks old) have disagreed with it for D consecutive clocks.
    logic [D:0] m_hist;
    logic m_lvl, m_rise, m_press;
    int m_step;
    logic [W-1:0] m_c [3];
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_hist <= '0;
            m_lvl <= 1'b0;
            m_rise <= 1'b0;
            m_press <= 1'b0;
            m_step <= 0;
            m_c[0] <= '0;
            m_c[1] <= '0;
            m_c[2] <= '0;
        end else begin
            m_hist <= {m_hist[D-1:0], btn};
            if (m_hist[D:1] == {D{~m_lvl}}) m_lvl <= ~m_lvl;
            m_rise <= (m_hist[D:1] == {D{~m_lvl}}) && !m_lvl;
            m_press <= m_rise;
            if (m_step == 3) m_step <= 0;
            else if (m_press) begin
                m_c[m_step] <= sw;
                m_step <= m_step + 1;
            end
        end
    end

    always @(negedge clk) begin
        chk("R", int'(R), int'(m_c[0]));
        chk("G", int'(G), int'(m_c[1]));
        chk("B", int'(B), int'(m_c[2]));
        chk("sel", int'(sel), m_step == 3 ? 0 : (1 << m_step));
        chk("enter", int'(enter), int'(m_step == 3));
        if (enter === 1'b1) n_enter++;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_btn(input logic [W-1:0] v, input int hold);
        sw = v;
        btn = 1'b1;
        cyc(hold);
        btn = 1'b0;
        cyc(12);
    endtask

    initial begin
        cyc(3);
        chk("rst_R", int'(R), 0);
        chk("rst_sel", int'(sel), 1);
        chk("rst_enter", int'(enter), 0);
        reset = 1'b0;
        cyc(2);
        for (int n = 1; n <= 3; n++) begin
            btn = 1'b1;
            cyc(n);
            btn = 1'b0;
            cyc(6);
        end
        chk("glitch_R", int'(R), 0);
        chk("glitch_sel", int'(sel), 1);
        sw = 5;
        btn = 1'b1;
        lat = 0;
        while (sel == 3'b001 && lat < 30) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("press_latency_ok", int'(lat >= 7 && lat <= 9), 1);
        cyc(8);
        btn = 1'b0;
        cyc(12);
        chk("cap_R", int'(R), 5);
        chk("sel_G", int'(sel), 2);
        sw = 31;
        cyc(10);
        chk("sw_change_R", int'(R), 5);
        press_btn(10, 10);
        chk("cap_G", int'(G), 10);
        chk("sel_B", int'(sel), 4);
        e0 = n_enter;
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("arst_R", int'(R), 0);
        chk("arst_G", int'(G), 0);
        chk("arst_sel", int'(sel), 1);
        chk("arst_enter", int'(enter), 0);
        cyc(2);
        reset = 1'b0;
        cyc(2);
        chk("arst_no_enter", n_enter - e0, 0);
        press_btn(5, 10);
        sw = 7;
        btn = 1'b1;
        cyc(200);
        chk("hold_G", int'(G), 7);
        chk("hold_sel", int'(sel), 4);
        btn = 1'b0;
        cyc(12);
        chk("hold_G_after", int'(G), 7);
        press_btn(15, 10);
        chk("cap_B", int'(B), 15);
        chk("fire_back_R", int'(sel), 1);
        chk("one_enter", n_enter - e0, 1);
        press_btn(5, 10);
        press_btn(10, 10);
        press_btn(15, 10);
        press_btn(0, 10);
        press_btn(31, 10);
        press_btn(1, 10);
        chk("three_enters", n_enter - e0, 3);
        chk("final_R", int'(R), 0);
        chk("final_G", int'(G), 31);
        chk("final_B", int'(B), 1);
        chk("final_sel", int'(sel), 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
